gpio_bank: RTL and testbench

Register-mapped GPIO controller that sits inside the user project and owns the `io_out` / `io_oeb` / `io_in` pad interface. The block drives pads from software-visible registers, synchronises pad inputs and raises a level interrupt on enabled rising edges. Access is through a single-outstanding valid/ready request/response port used by the project's core or debug bridge.

---
 rtl/gpio_pkg.sv | 22 ++
 rtl/gpio_sync.sv | 33 +++
 rtl/gpio_bank.sv | 128 ++++++++++++
 tb/tb_gpio_bank.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register map, FSM states, default width.
package gpio_pkg;

  localparam int GPIO_NPINS = 36;

  // Register indices on the request port.
  localparam logic [2:0] GPIO_OUT  = 3'd0;
  localparam logic [2:0] GPIO_OEB  = 3'd1;
  localparam logic [2:0] GPIO_IN   = 3'd2;
  localparam logic [2:0] GPIO_SET  = 3'd3;
  localparam logic [2:0] GPIO_CLR  = 3'd4;
  localparam logic [2:0] GPIO_TGL  = 3'd5;
  localparam logic [2:0] GPIO_IEN  = 3'd6;
  localparam logic [2:0] GPIO_IFLG = 3'd7;

  // Request/response handshake: one transaction outstanding at a time.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/gpio_sync.sv
// Single-pad input conditioner: 2-flop synchroniser followed by a history
// flop so a rising edge can be detected in the clk domain.
module gpio_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;

  // Shift the asynchronous pad value through s1 -> s2 -> prev.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~prev;

endmodule

// File: rtl/gpio_bank.sv
// Register-mapped GPIO controller: drives the pads from software registers,
// synchronises pad inputs and flags enabled rising edges as a level interrupt.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int NPINS = GPIO_NPINS
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_addr,
  input  logic [NPINS-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [NPINS-1:0] rsp_rdata,
  input  logic [NPINS-1:0] io_in,
  output logic [NPINS-1:0] io_out,
  output logic [NPINS-1:0] io_oeb,
  output logic             irq
);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             wr;
  logic [NPINS-1:0] out_q;
  logic [NPINS-1:0] oeb_q;
  logic [NPINS-1:0] ien_q;
  logic [NPINS-1:0] iflg_q;
  logic [NPINS-1:0] iflg_w1c;
  logic [NPINS-1:0] rd_mux;
  logic [NPINS-1:0] sync;
  logic [NPINS-1:0] rise;

  // One conditioner per pad.
  for (genvar i = 0; i < NPINS; i++) begin : g_sync
    gpio_sync u_sync (
      .clk   (clk_i),
      .rst_n (rst_n),
      .d     (io_in[i]),
      .sync  (sync[i]),
      .rise  (rise[i])
    );
  end

  assign accept = req_valid & req_ready;
  assign wr     = accept & req_we;

  // Handshake state register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Software-visible control registers; SET/CLR/TGL are read-modify-write on OUT.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      oeb_q <= '1;
      ien_q <= '0;
    end else if (wr) begin
      case (req_addr)
        GPIO_OUT: out_q <= req_wdata;
        GPIO_OEB: oeb_q <= req_wdata;
        GPIO_SET: out_q <= out_q | req_wdata;
        GPIO_CLR: out_q <= out_q & ~req_wdata;
        GPIO_TGL: out_q <= out_q ^ req_wdata;
        GPIO_IEN: ien_q <= req_wdata;
        default:  ;
      endcase
    end
  end

  assign iflg_w1c = (wr && req_addr == GPIO_IFLG) ? req_wdata : '0;

  // Interrupt flags: clear-by-write-one first, then OR in new edges so a
  // same-cycle edge survives the clear.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) iflg_q <= '0;
    else        iflg_q <= (iflg_q & ~iflg_w1c) | (rise & ien_q);
  end

  // Read mux; write-only registers read as zero.
  always_comb begin
    rd_mux = '0;
    case (req_addr)
      GPIO_OUT:  rd_mux = out_q;
      GPIO_OEB:  rd_mux = oeb_q;
      GPIO_IN:   rd_mux = sync;
      GPIO_IEN:  rd_mux = ien_q;
      GPIO_IFLG: rd_mux = iflg_q;
      default:   rd_mux = '0;
    endcase
  end

  // Capture response data at accept; held until the next accept.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)      rsp_rdata <= '0;
    else if (accept) rsp_rdata <= req_we ? '0 : rd_mux;
  end

  assign io_out = out_q;
  assign io_oeb = oeb_q;
  assign irq    = |iflg_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: a transaction-level model is compared
// against the DUT on every falling edge, with literal checks pinning the model.
module tb_gpio_bank;

  localparam int N = 36;

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [2:0]   req_addr;
  logic [N-1:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_rdata;
  logic [N-1:0] io_in;
  logic [N-1:0] io_out;
  logic [N-1:0] io_oeb;
  logic         irq;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  gpio_bank #(.NPINS(N)) dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq       (irq)
  );

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register file, busy flag for the pending response,
  // and the pad value seen at each of the last three clock edges.
  typedef struct {
    logic [N-1:0] out, oeb, ien, iflg, rd;
    logic         busy;
    logic [N-1:0] pad1, pad2, pad3;  // pad sampled 1, 2, 3 edges ago
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.out = '0; r.oeb = '1; r.ien = '0; r.iflg = '0; r.rd = '0;
    r.busy = 1'b0; r.pad1 = '0; r.pad2 = '0; r.pad3 = '0;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, logic v, logic we, logic [2:0] a,
                                        logic [N-1:0] wd, logic rr, logic [N-1:0] pad);
    model_t       n = c;
    logic [N-1:0] edges = c.pad2 & ~c.pad3;  // synchronised value went 0 -> 1
    logic [N-1:0] clr = '0;
    n.pad1 = pad; n.pad2 = c.pad1; n.pad3 = c.pad2;
    if (!c.busy) begin
      if (v) begin
        n.busy = 1'b1;
        n.rd   = '0;
        if (we) begin
          if (a == 3'd0) n.out  = wd;
          if (a == 3'd1) n.oeb  = wd;
          if (a == 3'd3) n.out  = c.out | wd;
          if (a == 3'd4) n.out  = c.out & ~wd;
          if (a == 3'd5) n.out  = c.out ^ wd;
          if (a == 3'd6) n.ien  = wd;
          if (a == 3'd7) clr    = wd;
        end else begin
          if (a == 3'd0) n.rd = c.out;
          if (a == 3'd1) n.rd = c.oeb;
          if (a == 3'd2) n.rd = c.pad2;
          if (a == 3'd6) n.rd = c.ien;
          if (a == 3'd7) n.rd = c.iflg;
        end
      end
    end else if (rr) begin
      n.busy = 1'b0;
    end
    n.iflg = (c.iflg & ~clr) | (edges & c.ien);
    return n;
  endfunction

  // Model advances on the same edges as the DUT.
  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, req_valid, req_we, req_addr, req_wdata, rsp_ready, io_in);
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk_i) begin
    check("io_out",    io_out,    m.out);
    check("io_oeb",    io_oeb,    m.oeb);
    check("irq",       irq,       |m.iflg);
    check("req_ready", req_ready, !m.busy);
    check("rsp_valid", rsp_valid, m.busy);
    if (m.busy) check("rsp_rdata", rsp_rdata, m.rd);
  end

  // One transaction with rsp_ready held high; returns at a falling edge
  // after the response handshake.
  task automatic xact(input logic we, input logic [2:0] a, input logic [N-1:0] wd,
                      output logic [N-1:0] rd);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (n == 20) check("accept_timeout", 1'b1, 1'b0);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    @(negedge clk_i);
    req_valid = 1'b0;
    check("rsp_latency", rsp_valid, 1'b1);
    rd = rsp_rdata;
    @(negedge clk_i);
  endtask

  logic [N-1:0] rd;
  logic [N-1:0] held;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b1; io_in = '0;
    @(negedge clk_i);
    check("rst_oeb",   io_oeb, 36'hF_FFFF_FFFF);
    check("rst_out",   io_out, '0);
    check("rst_irq",   irq, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_valid", rsp_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk_i);

    // Output register arithmetic.
    xact(1'b1, 3'd1, '0, rd);              check("wr_oeb_rdata", rd, '0);
    xact(1'b1, 3'd0, 36'hA_5A5A_5A5A, rd); check("wr_out_rdata", rd, '0);
    xact(1'b1, 3'd3, 36'h1, rd);
    xact(1'b1, 3'd4, 36'h2, rd);
    xact(1'b1, 3'd5, 36'hF_0000_0000, rd); check("wr_tgl_rdata", rd, '0);
    check("out_after_rmw", io_out, 36'h5_5A5A_5A59);
    check("oeb_written",   io_oeb, '0);
    xact(1'b0, 3'd3, '0, rd);              check("rd_set_zero", rd, '0);
    xact(1'b0, 3'd0, '0, rd);              check("rd_out", rd, 36'h5_5A5A_5A59);

    // Pad-to-IN latency.
    io_in = 36'h1234;
    @(negedge clk_i);
    xact(1'b0, 3'd2, '0, rd);              check("rd_in_early", rd, '0);
    xact(1'b0, 3'd2, '0, rd);              check("rd_in_late", rd, 36'h1234);

    // Edge interrupt on an enabled pin.
    xact(1'b1, 3'd6, 36'h8, rd);
    io_in = '0;
    repeat (4) @(negedge clk_i);
    io_in[3] = 1'b1;
    @(negedge clk_i); check("irq_edge1", irq, 1'b0);
    @(negedge clk_i); check("irq_edge2", irq, 1'b0);
    @(negedge clk_i); check("irq_edge3", irq, 1'b1);
    xact(1'b0, 3'd7, '0, rd);              check("iflg_pin3", rd, 36'h8);
    io_in[4] = 1'b1;
    repeat (4) @(negedge clk_i);
    xact(1'b0, 3'd7, '0, rd);              check("iflg_pin4_masked", rd, 36'h8);
    xact(1'b1, 3'd7, 36'h8, rd);           check("irq_w1c", irq, 1'b0);

    // Response back-pressure: a second request must not be taken.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd0; req_wdata = '0;
    @(negedge clk_i);
    req_we = 1'b1; req_wdata = '0;
    held = rsp_rdata;
    check("stall_first", held, 36'h5_5A5A_5A59);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_rdata", rsp_rdata, held);
      check("stall_ready", req_ready, 1'b0);
      check("stall_out",   io_out, 36'h5_5A5A_5A59);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk_i);
    check("stall_release", rsp_valid, 1'b0);

    // W1C and a new edge on the same bit at the same clock edge.
    io_in[3] = 1'b0;
    repeat (4) @(negedge clk_i);
    io_in[3] = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    xact(1'b1, 3'd7, 36'h8, rd);
    check("w1c_race_irq", irq, 1'b1);
    xact(1'b0, 3'd7, '0, rd);              check("w1c_race_iflg", rd, 36'h8);

    // Asynchronous reset during an outstanding response.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd6;
    @(negedge clk_i);
    req_valid = 1'b0;
    check("pre_rst_valid", rsp_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", rsp_valid, 1'b0);
    check("async_rst_ready", req_ready, 1'b1);
    check("async_rst_out",   io_out, '0);
    check("async_rst_oeb",   io_oeb, 36'hF_FFFF_FFFF);
    check("async_rst_irq",   irq, 1'b0);
    check("async_rst_rdata", rsp_rdata, '0);
    @(negedge clk_i);
    rst_n = 1'b1; rsp_ready = 1'b1;
    // Pads 3 and 4 are high at release: edges appear but IEN is cleared.
    repeat (6) @(negedge clk_i);
    check("post_rst_irq", irq, 1'b0);
    xact(1'b0, 3'd7, '0, rd);              check("post_rst_iflg", rd, '0);
    xact(1'b0, 3'd2, '0, rd);              check("post_rst_in", rd, 36'h18);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
